des_key_schedule: RTL and testbench
===================================

# des_key_schedule

Sequential DES key-schedule generator sitting directly upstream of the Feistel network. It accepts a 64-bit DES key with a valid/ready handshake and derives the sixteen 48-bit round keys K1..K16, one round per clock (PC-1, per-round left rotations, PC-2). It stores them in a register bank and presents them on sixteen parallel 48-bit outputs that wire straight into the Feistel network's K1..K16 inputs. A latched mode bit selects encryption order or reversed (decryption) order on the outputs.

## Interface
- No parameters; all widths are fixed by DES.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- key  input  64  DES key; key[63] is DES bit 1; parity bits 8,16,…,64 are ignored.
- decrypt  input  1  sampled with key at accept; 1 = reversed key order.
- key_valid  input  1  key/decrypt are valid this cycle.
- key_ready  output  1  block can accept a key this cycle.
- keys_valid  output  1  K1..K16 hold a complete, consistent schedule.
- K1 … K16  output  48 each  round keys; K1[47] is PC-2 output bit 1.

## Operation
- Accept occurs on a rising edge where key_valid && key_ready.
- States:
  - IDLE (after reset): key_ready=1, keys_valid=0.
  - GEN: key_ready=0, keys_valid=0.
  - DONE: key_ready=1, keys_valid=1.
- Accept (from IDLE or DONE):
  - C,D (28 bits each) <= PC-1(key).
  - mode <= decrypt.
  - round counter <= 1.
  - state <= GEN.
- GEN, each cycle with counter i (1..16):
  - C,D <= rotate-left by s(i); s(i)=1 for i∈{1,2,9,16}, else 2.
  - bank[i] <= PC-2 of the rotated {C,D}.
  - counter <= i+1.
  - After writing bank[16]: state <= DONE.
- Total rotation across all rounds is 28, so C,D return to their PC-1 values in DONE.
- Output mapping:
  - mode=0: Kn = bank[n].
  - mode=1: Kn = bank[17−n].
  - Mapping is combinational from the bank and the latched mode only; it never depends on the live decrypt input.
- Accept in DONE: restart GEN with the new key; keys_valid drops on that same edge.
- The bank is not cleared on accept. During GEN, K outputs show a mix of old and new entries; consumers use K* only while keys_valid=1.
- key_valid while key_ready=0 (GEN): ignored, no queuing. The upstream must hold key_valid until accepted.
- Keys differing only in parity bits produce identical schedules.

## Timing
- Reset (rst high at an edge, from any state, including mid-GEN):
  - state=IDLE, key_ready=1, keys_valid=0.
  - bank all zero, so every K output = 48'h0.
  - C,D=0, mode=0, counter=0.
  - rst dominates a simultaneous key_valid.
- Latency: accept at edge E0; bank[1] written at E1 … bank[16] at E16; keys_valid=1 and key_ready=1 in the cycle after E16. This is 16 cycles accept-to-valid.
- Throughput: one key per 16 cycles. Back-to-back is possible by asserting key_valid in the first DONE cycle.
- keys_valid and key_ready are registered (state decode only), with no combinational path from key_valid.
- K outputs change only on edges that write the bank, and on accept edges (mode change).

## Test plan
- Key 64'h133457799BBCDFF1, decrypt=0, from IDLE -> key_ready low for 16 cycles, then keys_valid=1; K1=48'h1B02EFFC7072, K2=48'h79AED9DBC9E5, K16=48'hCB3D8B0E17F5.
- Same key with decrypt=1 -> after 16 cycles K1=48'hCB3D8B0E17F5, K16=48'h1B02EFFC7072, K15=48'h79AED9DBC9E5.
- Key 64'h133457799BBCDFF1 ^ 64'h0101010101010101 -> schedule identical to scenario 1; key 64'h0 -> all K = 48'h0.
- Accept in GEN cycle 5 attempted (key_valid=1, different key) -> ignored, original schedule completes; then accept in first DONE cycle -> keys_valid low on next edge, new schedule valid 16 cycles later.
- rst asserted in GEN cycle 8 -> next cycle: keys_valid=0, key_ready=1, all K=0; a new key then gives correct keys after 16 cycles.
- Chain with Feistel network: key 64'h133457799BBCDFF1, plaintext 64'h0123456789ABCDEF -> ciphertext 64'h85E813540F0AB405; decrypt=1 with that ciphertext returns the plaintext.

Source files
------------

// File: rtl/des_key_schedule.sv
// DES key schedule: accepts a 64-bit key, derives K1..K16 one round per clock
// into a register bank, and presents them in encryption or decryption order.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key,
  input  logic        decrypt,
  input  logic        key_valid,
  output logic        key_ready,
  output logic        keys_valid,
  output logic [47:0] K1,
  output logic [47:0] K2,
  output logic [47:0] K3,
  output logic [47:0] K4,
  output logic [47:0] K5,
  output logic [47:0] K6,
  output logic [47:0] K7,
  output logic [47:0] K8,
  output logic [47:0] K9,
  output logic [47:0] K10,
  output logic [47:0] K11,
  output logic [47:0] K12,
  output logic [47:0] K13,
  output logic [47:0] K14,
  output logic [47:0] K15,
  output logic [47:0] K16
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Table entries are DES bit numbers, 1 = most significant bit.
  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int unsigned i = 0; i < 56; i++) begin
      r[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int unsigned i = 0; i < 48; i++) begin
      r[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
    end
    return r;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic by_one);
    return by_one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic        mode_q, mode_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        key_ready_q, key_ready_d;
  logic        keys_valid_q, keys_valid_d;
  logic [47:0] bank_q [16];
  logic [47:0] bank_d [16];
  logic [47:0] k_sel  [16];

  logic [27:0] c_rot, d_rot;
  logic        shift_one;
  logic [3:0]  wr_idx;

  // Parity bits 8,16,...,64 never enter the schedule.
  logic unused_parity;
  assign unused_parity = ^{key[56], key[48], key[40], key[32],
                           key[24], key[16], key[8],  key[0]};

  // Next-state: accept from IDLE/DONE, one round per cycle in GEN.
  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    d_d       = d_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    bank_d    = bank_q;
    shift_one = (cnt_q == 5'd1) || (cnt_q == 5'd2) ||
                (cnt_q == 5'd9) || (cnt_q == 5'd16);
    c_rot     = rotl28(c_q, shift_one);
    d_rot     = rotl28(d_q, shift_one);
    wr_idx    = 4'(cnt_q - 5'd1);
    case (state_q)
      IDLE, DONE: begin
        if (key_valid) begin
          {c_d, d_d} = pc1(key);
          mode_d     = decrypt;
          cnt_d      = 5'd1;
          state_d    = GEN;
        end
      end
      GEN: begin
        c_d            = c_rot;
        d_d            = d_rot;
        bank_d[wr_idx] = pc2({c_rot, d_rot});
        cnt_d          = cnt_q + 5'd1;
        if (cnt_q == 5'd16) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    key_ready_d  = (state_d != GEN);
    keys_valid_d = (state_d == DONE);
  end

  // State, schedule bank and handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      c_q          <= '0;
      d_q          <= '0;
      mode_q       <= 1'b0;
      cnt_q        <= '0;
      key_ready_q  <= 1'b1;
      keys_valid_q <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      c_q          <= c_d;
      d_q          <= d_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      key_ready_q  <= key_ready_d;
      keys_valid_q <= keys_valid_d;
      bank_q       <= bank_d;
    end
  end

  // Output order follows the latched mode, never the live decrypt input.
  always_comb begin
    for (int unsigned n = 0; n < 16; n++) begin
      k_sel[n] = mode_q ? bank_q[4'(15 - n)] : bank_q[n];
    end
  end

  assign key_ready  = key_ready_q;
  assign keys_valid = keys_valid_q;
  assign K1  = k_sel[0];
  assign K2  = k_sel[1];
  assign K3  = k_sel[2];
  assign K4  = k_sel[3];
  assign K5  = k_sel[4];
  assign K6  = k_sel[5];
  assign K7  = k_sel[6];
  assign K8  = k_sel[7];
  assign K9  = k_sel[8];
  assign K10 = k_sel[9];
  assign K11 = k_sel[10];
  assign K12 = k_sel[11];
  assign K13 = k_sel[12];
  assign K14 = k_sel[13];
  assign K15 = k_sel[14];
  assign K16 = k_sel[15];

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: known-answer keys plus random keys checked
// against a reference schedule computed from cumulative rotation amounts.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] key = '0;
  logic        decrypt = 1'b0;
  logic        key_valid = 1'b0;
  logic        key_ready, keys_valid;
  logic [47:0] K1, K2, K3, K4, K5, K6, K7, K8;
  logic [47:0] K9, K10, K11, K12, K13, K14, K15, K16;

  logic [47:0] kq    [1:16];
  logic [47:0] exp_k [1:16];

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] KEY1  = 64'h133457799BBCDFF1;
  localparam logic [47:0] KA_1  = 48'h1B02EFFC7072;
  localparam logic [47:0] KA_2  = 48'h79AED9DBC9E5;
  localparam logic [47:0] KA_16 = 48'hCB3D8B0E17F5;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  always #5 clk = ~clk;

  des_key_schedule dut (
    .clk(clk), .rst(rst), .key(key), .decrypt(decrypt), .key_valid(key_valid),
    .key_ready(key_ready), .keys_valid(keys_valid),
    .K1(K1), .K2(K2), .K3(K3), .K4(K4), .K5(K5), .K6(K6), .K7(K7), .K8(K8),
    .K9(K9), .K10(K10), .K11(K11), .K12(K12), .K13(K13), .K14(K14),
    .K15(K15), .K16(K16)
  );

  assign kq[1]  = K1;  assign kq[2]  = K2;  assign kq[3]  = K3;  assign kq[4]  = K4;
  assign kq[5]  = K5;  assign kq[6]  = K6;  assign kq[7]  = K7;  assign kq[8]  = K8;
  assign kq[9]  = K9;  assign kq[10] = K10; assign kq[11] = K11; assign kq[12] = K12;
  assign kq[13] = K13; assign kq[14] = K14; assign kq[15] = K15; assign kq[16] = K16;

  // Reference: round n uses C0/D0 rotated by the running total of shifts.
  task automatic build_model(input logic [63:0] k, input logic dec);
    longint unsigned cd0, c0, d0, c, d, cd, rk;
    logic [47:0] rounds [1:16];
    int tot;
    cd0 = 0;
    for (int i = 0; i < 56; i++) cd0 = (cd0 << 1) | ((k >> (64 - PC1[i])) & 64'd1);
    c0  = cd0 >> 28;
    d0  = cd0 & 64'h0FFF_FFFF;
    tot = 0;
    for (int n = 1; n <= 16; n++) begin
      tot = tot + SHIFTS[n - 1];
      c   = ((c0 << tot) | (c0 >> (28 - tot))) & 64'h0FFF_FFFF;
      d   = ((d0 << tot) | (d0 >> (28 - tot))) & 64'h0FFF_FFFF;
      cd  = (c << 28) | d;
      rk  = 0;
      for (int j = 0; j < 48; j++) rk = (rk << 1) | ((cd >> (56 - PC2[j])) & 64'd1);
      rounds[n] = rk[47:0];
    end
    for (int n = 1; n <= 16; n++) exp_k[n] = dec ? rounds[17 - n] : rounds[n];
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_accept(input logic [63:0] k, input logic dec);
    key       = k;
    decrypt   = dec;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  // Bounded wait for keys_valid; reports edges waited and whether key_ready rose.
  task automatic wait_valid(output int cycles, output bit leak);
    cycles = 0;
    leak   = 1'b0;
    while (!keys_valid && cycles < 40) begin
      if (key_ready) leak = 1'b1;
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; key_valid = 1'b1; key = KEY1;
    tick(); tick();
    rst = 1'b0; key_valid = 1'b0;
    n_cmp++;
    if (key_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b expected 1", key_ready); end
    n_cmp++;
    if (keys_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b expected 0", keys_valid); end
    for (int n = 1; n <= 16; n++) begin
      n_cmp++;
      if (kq[n] !== 48'h0) begin n_bad++; $display("FAIL reset_K%0d got %h expected 0", n, kq[n]); end
    end
    tick();
    n_cmp++;
    if (key_ready !== 1'b1) begin n_bad++; $display("FAIL reset_dominates got ready=%b expected 1", key_ready); end
  endtask

  task automatic test_known_enc;
    int cyc; bit leak;
    build_model(KEY1, 1'b0);
    do_accept(KEY1, 1'b0);
    wait_valid(cyc, leak);
    n_cmp++;
    if (cyc != 16) begin n_bad++; $display("FAIL enc_latency got %0d expected 16", cyc); end
    n_cmp++;
    if (leak !== 1'b0) begin n_bad++; $display("FAIL enc_ready_in_gen got 1 expected 0"); end
    n_cmp++;
    if (key_ready !== 1'b1) begin n_bad++; $display("FAIL enc_ready_done got %b expected 1", key_ready); end
    n_cmp++;
    if (K1 !== KA_1) begin n_bad++; $display("FAIL enc_K1 got %h expected %h", K1, KA_1); end
    n_cmp++;
    if (K2 !== KA_2) begin n_bad++; $display("FAIL enc_K2 got %h expected %h", K2, KA_2); end
    n_cmp++;
    if (K16 !== KA_16) begin n_bad++; $display("FAIL enc_K16 got %h expected %h", K16, KA_16); end
    for (int n = 1; n <= 16; n++) begin
      n_cmp++;
      if (kq[n] !== exp_k[n]) begin n_bad++; $display("FAIL enc_K%0d got %h expected %h", n, kq[n], exp_k[n]); end
    end
  endtask

  task automatic test_known_dec;
    int cyc; bit leak;
    build_model(KEY1, 1'b1);
    do_accept(KEY1, 1'b1);
    wait_valid(cyc, leak);
    n_cmp++;
    if (cyc != 16) begin n_bad++; $display("FAIL dec_latency got %0d expected 16", cyc); end
    n_cmp++;
    if (K1 !== KA_16) begin n_bad++; $display("FAIL dec_K1 got %h expected %h", K1, KA_16); end
    n_cmp++;
    if (K16 !== KA_1) begin n_bad++; $display("FAIL dec_K16 got %h expected %h", K16, KA_1); end
    n_cmp++;
    if (K15 !== KA_2) begin n_bad++; $display("FAIL dec_K15 got %h expected %h", K15, KA_2); end
    for (int n = 1; n <= 16; n++) begin
      n_cmp++;
      if (kq[n] !== exp_k[n]) begin n_bad++; $display("FAIL dec_K%0d got %h expected %h", n, kq[n], exp_k[n]); end
    end
    // Live decrypt toggling without an accept must not reorder the outputs.
    decrypt = 1'b0;
    tick();
    n_cmp++;
    if (K1 !== KA_16) begin n_bad++; $display("FAIL dec_live_mode got %h expected %h", K1, KA_16); end
  endtask

  task automatic test_parity_and_zero;
    int cyc; bit leak;
    do_accept(KEY1 ^ 64'h0101010101010101, 1'b0);
    wait_valid(cyc, leak);
    n_cmp++;
    if (K1 !== KA_1) begin n_bad++; $display("FAIL parity_K1 got %h expected %h", K1, KA_1); end
    n_cmp++;
    if (K2 !== KA_2) begin n_bad++; $display("FAIL parity_K2 got %h expected %h", K2, KA_2); end
    n_cmp++;
    if (K16 !== KA_16) begin n_bad++; $display("FAIL parity_K16 got %h expected %h", K16, KA_16); end
    do_accept(64'h0, 1'b0);
    wait_valid(cyc, leak);
    n_cmp++;
    if (cyc != 16) begin n_bad++; $display("FAIL zero_latency got %0d expected 16", cyc); end
    for (int n = 1; n <= 16; n++) begin
      n_cmp++;
      if (kq[n] !== 48'h0) begin n_bad++; $display("FAIL zero_K%0d got %h expected 0", n, kq[n]); end
    end
  endtask

  task automatic test_ignore_in_gen;
    int cyc; bit leak;
    logic [63:0] ka, kb;
    ka = {$urandom, $urandom};
    kb = ~ka;
    build_model(ka, 1'b0);
    do_accept(ka, 1'b0);
    repeat (4) tick();
    key = kb; decrypt = 1'b1; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    wait_valid(cyc, leak);
    n_cmp++;
    if (cyc + 5 != 16) begin n_bad++; $display("FAIL ignore_latency got %0d expected 16", cyc + 5); end
    for (int n = 1; n <= 16; n++) begin
      n_cmp++;
      if (kq[n] !== exp_k[n]) begin n_bad++; $display("FAIL ignore_K%0d got %h expected %h", n, kq[n], exp_k[n]); end
    end
  endtask

  task automatic test_back_to_back;
    int cyc; bit leak;
    logic [63:0] kc;
    kc = {$urandom, $urandom};
    build_model(kc, 1'b1);
    do_accept(kc, 1'b1);
    n_cmp++;
    if (keys_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_drop got %b expected 0", keys_valid); end
    n_cmp++;
    if (key_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_drop got %b expected 0", key_ready); end
    wait_valid(cyc, leak);
    n_cmp++;
    if (cyc != 16) begin n_bad++; $display("FAIL b2b_latency got %0d expected 16", cyc); end
    for (int n = 1; n <= 16; n++) begin
      n_cmp++;
      if (kq[n] !== exp_k[n]) begin n_bad++; $display("FAIL b2b_K%0d got %h expected %h", n, kq[n], exp_k[n]); end
    end
  endtask

  task automatic test_reset_mid_gen;
    int cyc; bit leak;
    logic [63:0] kd;
    do_accept({$urandom, $urandom}, 1'b0);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (keys_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %b expected 0", keys_valid); end
    n_cmp++;
    if (key_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got %b expected 1", key_ready); end
    for (int n = 1; n <= 16; n++) begin
      n_cmp++;
      if (kq[n] !== 48'h0) begin n_bad++; $display("FAIL midrst_K%0d got %h expected 0", n, kq[n]); end
    end
    kd = {$urandom, $urandom};
    build_model(kd, 1'b0);
    do_accept(kd, 1'b0);
    wait_valid(cyc, leak);
    n_cmp++;
    if (cyc != 16) begin n_bad++; $display("FAIL midrst_latency got %0d expected 16", cyc); end
    for (int n = 1; n <= 16; n++) begin
      n_cmp++;
      if (kq[n] !== exp_k[n]) begin n_bad++; $display("FAIL midrst_K%0d got %h expected %h", n, kq[n], exp_k[n]); end
    end
  endtask

  task automatic test_random;
    int cyc; bit leak;
    logic [63:0] kr;
    logic dr;
    for (int t = 0; t < 12; t++) begin
      kr = {$urandom, $urandom};
      dr = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) tick();
      build_model(kr, dr);
      do_accept(kr, dr);
      wait_valid(cyc, leak);
      n_cmp++;
      if (cyc != 16 || leak) begin
        n_bad++; $display("FAIL rand%0d_timing got %0d leak=%b expected 16 leak=0", t, cyc, leak);
      end
      for (int n = 1; n <= 16; n++) begin
        n_cmp++;
        if (kq[n] !== exp_k[n]) begin
          n_bad++; $display("FAIL rand%0d_K%0d got %h expected %h", t, n, kq[n], exp_k[n]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_enc();
    test_known_dec();
    test_parity_and_zero();
    test_ignore_in_gen();
    test_back_to_back();
    test_reset_mid_gen();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
